// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data port arbiter that sequences each access into 1-4 little-endian byte cycles on a byte-wide RAM
module mem_arbiter #(
    parameter int ADDR_L   = 32,
    parameter int DATA_L   = 32,
    parameter int M_DATA_L = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_L-1:0]   if_addr,
    output logic [DATA_L-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_size,
    input  logic [ADDR_L-1:0]   d_addr,
    input  logic [DATA_L-1:0]   d_wdata,
    output logic [DATA_L-1:0]   d_rdata,
    output logic                d_ack,
    input  logic [M_DATA_L-1:0] m_dout,
    output logic [M_DATA_L-1:0] m_din,
    output logic [ADDR_L-1:0]   m_raddr,
    output logic [ADDR_L-1:0]   m_waddr,
    output logic                m_re,
    output logic                m_we,
    output logic                busy
);
    localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, RD_LAST = 3'd2, WR = 3'd3, DONE = 3'd4;
    logic [2:0]        state;
    logic              port, last_grant, grant_d;
    logic [1:0]        cnt, last, prev;
    logic [ADDR_L-1:0] base;
    logic [DATA_L-1:0] wdata, rbuf, rword;
    assign grant_d = d_req && (!if_req || !last_grant);
    assign prev    = cnt - 2'd1;
    assign m_re    = state == RD;
    assign m_we    = state == WR;
    assign m_raddr = base + ADDR_L'(cnt);
    assign m_waddr = base + ADDR_L'(cnt);
    assign m_din   = wdata[M_DATA_L*cnt +: M_DATA_L];
    assign busy    = state != IDLE;
    assign if_ack  = state == DONE && !port;
    assign d_ack   = state == DONE && port;
    always_comb begin
        rword = rbuf;
        rword[M_DATA_L*cnt +: M_DATA_L] = m_dout;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            port       <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            last       <= '0;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (if_req || d_req) begin
                    port  <= grant_d;
                    base  <= grant_d ? d_addr : if_addr;
                    last  <= !grant_d ? 2'd3 : d_size == 2'd0 ? 2'd0 : d_size == 2'd1 ? 2'd1 : 2'd3;
                    wdata <= d_wdata;
                    cnt   <= '0;
                    rbuf  <= '0;
                    state <= (grant_d && d_we) ? WR : RD;
                end
                RD: begin
                    // m_dout carries the byte addressed in the previous RD cycle
                    if (cnt != 2'd0) rbuf[M_DATA_L*prev +: M_DATA_L] <= m_dout;
                    if (cnt == last) state <= RD_LAST;
                    else cnt <= cnt + 2'd1;
                end
                RD_LAST: begin
                    rbuf <= rword;
                    if (port) d_rdata <= rword;
                    else if_rdata <= rword;
                    state <= DONE;
                end
                WR: if (cnt == last) state <= DONE;
                    else cnt <= cnt + 2'd1;
                DONE: begin
                    last_grant <= port;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory sequencer between the CPU and the byte-wide RAM. Arbitrates an instruction-fetch port (word reads only) and a data port (byte/half/word reads and writes). Converts each granted access into 1–4 consecutive little-endian byte cycles on the RAM port, and returns assembled 32-bit read data with a one-cycle acknowledge.

## Interface
- ADDR_L, 32, address width (CPU and RAM side)
- DATA_L, 32, CPU-side data width
- M_DATA_L, 8, RAM-side data width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_L  fetch byte address
- if_rdata  out  DATA_L  fetched word, valid with if_ack, held until next if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- d_addr  in  ADDR_L  data byte address
- d_wdata  in  DATA_L  write data; low bytes used first
- d_rdata  out  DATA_L  read data, zero-extended, valid with d_ack, held until next read d_ack
- d_ack  out  1  one-cycle completion pulse
- m_dout  in  M_DATA_L  RAM read byte, valid the cycle after m_re
- m_din  out  M_DATA_L  RAM write byte
- m_raddr  out  ADDR_L  RAM read address
- m_waddr  out  ADDR_L  RAM write address
- m_re  out  1  RAM read strobe
- m_we  out  1  RAM write strobe
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RD, RD_LAST, WR, DONE.
- IDLE: requests are sampled only here.
  - One requester high: that requester is granted.
  - Both high: the requester not granted last time wins.
  - last_grant resets to fetch, so the data port wins the first tie.
  - On grant, latch port, address, N (fetch: 4; data: 1/2/4 from d_size), we, and wdata; clear the byte counter and the read shift register.
  - Go to RD or WR.
- RD: each cycle, m_re=1 and m_raddr=base+cnt.
  - From the second RD cycle on, capture m_dout into byte cnt−1.
  - After issuing byte N−1, go to RD_LAST.
- RD_LAST: m_re=0; capture byte N−1; go to DONE.
- WR: each cycle, m_we=1, m_waddr=base+cnt, m_din=wdata[8·cnt+7:8·cnt]; after byte N−1, go to DONE.
- DONE: pulse the granted port's ack; for reads, drive the assembled word to that port's rdata; update last_grant; go to IDLE.
- Address arithmetic: base+cnt computed modulo 2^ADDR_L, so 0xFFFFFFFF+1 wraps to 0x00000000. No alignment requirement.
- Reads with N<4 zero the upper bytes. Sign extension is the CPU's job.
- The non-granted requester waits, holding its request. It is never dropped.
- Outputs when idle: m_re=m_we=0. m_raddr/m_waddr/m_din hold their last values (don't-care).

## Timing
- Reset (rst=0 at a clock edge):
  - State = IDLE, cnt=0, last_grant=fetch.
  - All outputs zero: if_ack, d_ack, m_re, m_we, busy, if_rdata, d_rdata, m_din, m_raddr, m_waddr.
- Reset mid-transaction: aborts immediately. No ack, partial data discarded, strobes low from the next cycle.
- Request accepted in IDLE cycle A:
  - Read: m_re high in cycles A+1..A+N; bytes arrive A+2..A+N+1; ack and rdata in cycle A+N+2. Word read = ack 6 cycles after acceptance.
  - Write: m_we high in cycles A+1..A+N; ack in cycle A+N+1.
- The cycle after DONE is IDLE, so the next grant can occur in cycle DONE+1.
- Requesters must deassert req (or present a new request) in the cycle after ack. A req still high in IDLE is taken as a new request.
- ack never asserts in IDLE, RD, RD_LAST, or WR. Only one ack is high per cycle.
- Request inputs change only after ack. Inputs are latched at grant, so later changes do not affect the transaction in flight.

## Test plan
- Reset mid-read: rst low during RD → next cycle m_re=0, busy=0, no if_ack; rst high, then the same request completes normally.
- Fetch word: RAM[0x100..0x103]=0x13,0x05,0x00,0x00; if_req at 0x100 accepted in cycle A → m_raddr 0x100..0x103 in A+1..A+4; if_ack and if_rdata=0x00000513 in A+6.
- Data writes:
  - Half write d_wdata=0xAABBCCDD to 0x201 → m_we in two cycles, (0x201,0xDD) then (0x202,0xCC); d_ack 3 cycles after accept; RAM[0x203] unchanged.
  - Byte read back from 0x202 → d_rdata=0x000000CC.
- Arbitration: if_req and d_req both high from reset → data served first. Fetch granted the cycle after d_ack. A next simultaneous pair goes to data again, because fetch was last.
- Wrap: word read at 0xFFFFFFFE → m_raddr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; bytes assembled little-endian.
- Back-to-back: data read completes; d_req reasserted in the cycle after d_ack → second read accepted the cycle after DONE; no spurious ack and no lost cycle beyond that.
